// File: rtl/imul_share_arbiter.sv
// Shares one val/rdy integer multiplier between two requesters, one transaction in flight.
// Optional grant counters are compiled in with `define IMUL_SHARE_ARBITER_STATS_EN.
module imul_share_arbiter #(
    parameter int NBITS     = 32,
    parameter int CNT_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 in0_req_val,
    output logic                 in0_req_rdy,
    input  logic [2*NBITS-1:0]   in0_req_msg,

    input  logic                 in1_req_val,
    output logic                 in1_req_rdy,
    input  logic [2*NBITS-1:0]   in1_req_msg,

    output logic                 mul_req_val,
    input  logic                 mul_req_rdy,
    output logic [2*NBITS-1:0]   mul_req_msg,

    input  logic                 mul_resp_val,
    output logic                 mul_resp_rdy,
    input  logic [NBITS-1:0]     mul_resp_msg,

    output logic                 out0_resp_val,
    input  logic                 out0_resp_rdy,
    output logic [NBITS-1:0]     out0_resp_msg,

`ifdef IMUL_SHARE_ARBITER_STATS_EN
    output logic [CNT_NBITS-1:0] grant_cnt0,
    output logic [CNT_NBITS-1:0] grant_cnt1,
`endif

    output logic                 out1_resp_val,
    input  logic                 out1_resp_rdy,
    output logic [NBITS-1:0]     out1_resp_msg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q,  prio_d;

    logic   grant_val;
    logic   grant_sel;
    logic   owner_resp_rdy;
    logic   req_fire;
    logic   resp_fire;

    // The prio port wins a tie; grant_sel stays 0 with no grant so port 0's msg is forwarded.
    always_comb begin
        grant_val = 1'b0;
        grant_sel = 1'b0;
        if (prio_q ? in1_req_val : in0_req_val) begin
            grant_val = 1'b1;
            grant_sel = prio_q;
        end else if (prio_q ? in0_req_val : in1_req_val) begin
            grant_val = 1'b1;
            grant_sel = ~prio_q;
        end
    end

    always_comb begin
        owner_resp_rdy = owner_q ? out1_resp_rdy : out0_resp_rdy;
        req_fire       = (state_q == IDLE) && grant_val && mul_req_rdy;
        resp_fire      = (state_q == BUSY) && mul_resp_val && owner_resp_rdy;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = BUSY;
                    owner_d = grant_sel;
                    prio_d  = ~grant_sel;
                end
            end
            BUSY: begin
                if (resp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted, independent of stored state.
    always_comb begin
        in0_req_rdy   = 1'b0;
        in1_req_rdy   = 1'b0;
        mul_req_val   = 1'b0;
        mul_resp_rdy  = 1'b0;
        out0_resp_val = 1'b0;
        out1_resp_val = 1'b0;
        mul_req_msg   = grant_sel ? in1_req_msg : in0_req_msg;
        out0_resp_msg = mul_resp_msg;
        out1_resp_msg = mul_resp_msg;
        if (!reset) begin
            if (state_q == IDLE) begin
                mul_req_val = grant_val;
                in0_req_rdy = grant_val && !grant_sel && mul_req_rdy;
                in1_req_rdy = grant_val &&  grant_sel && mul_req_rdy;
            end else begin
                out0_resp_val = mul_resp_val && !owner_q;
                out1_resp_val = mul_resp_val &&  owner_q;
                mul_resp_rdy  = owner_resp_rdy;
            end
        end
    end

`ifdef IMUL_SHARE_ARBITER_STATS_EN
    localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;

    logic [CNT_NBITS-1:0] cnt0_q, cnt0_d;
    logic [CNT_NBITS-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req_fire && !grant_sel && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + CNT_NBITS'(1);
        end
        if (req_fire && grant_sel && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + CNT_NBITS'(1);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
`ifdef IMUL_SHARE_ARBITER_STATS_EN
            cnt0_q  <= '0;
            cnt1_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
`ifdef IMUL_SHARE_ARBITER_STATS_EN
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
`endif
        end
    end

endmodule
